vga_frame_update_scheduler: RTL

Buffers PicoBlaze port writes for the VGA pointer/register bank and commits them only during vertical sync, so on-screen objects never tear mid-frame. Sits between the PicoBlaze I/O strobes and the `PunterosVGA_MemoryPointed` write port inside the VGA central controller. It also provides a status byte for PicoBlaze polling that replaces the bare `~VSync` read.

---
 rtl/vga_sched_pkg.sv | 28 ++
 rtl/vga_frame_update_scheduler_if.sv | 18 +
 rtl/vga_sched_fifo.sv | 72 +++++++
 rtl/vga_frame_update_scheduler.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vga_sched_pkg.sv
// Shared types and bit positions for the VGA frame update scheduler.
package vga_sched_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ENTRY_W = 2 * BYTE_W;

  typedef enum logic [1:0] {
    S_ACTIVE = 2'd0,
    S_WINDOW = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } entry_t;

  localparam int unsigned ST_VS       = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_FULL     = 2;
  localparam int unsigned ST_OVF      = 3;
  localparam int unsigned ST_FRAME_LO = 4;
  localparam int unsigned ST_FRAME_HI = 7;

  localparam int unsigned CMD_FLUSH   = 0;
  localparam int unsigned CMD_CLR_OVF = 1;

endpackage

// File: rtl/vga_frame_update_scheduler_if.sv
// PicoBlaze I/O port bundle: the processor is master, the scheduler is slave.
interface vga_frame_update_scheduler_if;
  logic [7:0] Port_ID;
  logic [7:0] IN_DATA;
  logic       Write_Strobe;
  logic       Read_Strobe;
  logic [7:0] OUT_DATA;

  modport master (
    output Port_ID, IN_DATA, Write_Strobe, Read_Strobe,
    input  OUT_DATA
  );

  modport slave (
    input  Port_ID, IN_DATA, Write_Strobe, Read_Strobe,
    output OUT_DATA
  );
endinterface

// File: rtl/vga_sched_fifo.sv
// DEPTH-deep synchronous FIFO of {addr, data} entries with flush.
module vga_sched_fifo
  import vga_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push_c, do_pop_c;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign rd_data   = mem_q[rd_ptr_q];
  assign do_push_c = push && !full && !flush;
  assign do_pop_c  = pop && !empty && !flush;

  // Flush wins over any push or pop issued in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vga_frame_update_scheduler.sv
// Defers PicoBlaze pointer-bank writes to the vertical sync window.
// Optional build macro: VGA_SCHED_FRAMECNT_EN adds a 4-bit frame counter to the status byte.
module vga_frame_update_scheduler
  import vga_sched_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter logic [7:0]  STATUS_PORT = 8'hFF
) (
  input  logic                          CLK,
  input  logic                          RESET,
  vga_frame_update_scheduler_if.slave   pb,
  input  logic                          VSync,
  output logic [7:0]                    MemAddr,
  output logic [7:0]                    MemData,
  output logic                          MemWrite,
  output logic                          Full
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic             vs_q;
  logic             ovf_q, ovf_d;
  logic             mem_write_q, mem_write_d;
  logic [7:0]       mem_addr_q, mem_addr_d;
  logic [7:0]       mem_data_q, mem_data_d;
  logic [3:0]       frame_c;

  logic             is_status_c, push_c, cmd_c, flush_c, clr_ovf_c;
  logic             push_ok_c, pop_c, vs_fall_c, last_pop_c;
  logic             full_c, empty_c;
  logic [CNT_W-1:0] count_c;
  entry_t           rd_entry_c, push_entry_c;
  logic [7:0]       status_c;

  assign is_status_c  = (pb.Port_ID == STATUS_PORT);
  assign push_c       = pb.Write_Strobe && !is_status_c;
  assign cmd_c        = pb.Write_Strobe && is_status_c;
  assign flush_c      = cmd_c && pb.IN_DATA[CMD_FLUSH];
  assign clr_ovf_c    = (cmd_c && pb.IN_DATA[CMD_CLR_OVF]) || (pb.Read_Strobe && is_status_c);
  assign push_ok_c    = push_c && !full_c;
  assign vs_fall_c    = vs_q && !VSync;
  assign push_entry_c = '{addr: pb.Port_ID, data: pb.IN_DATA};

  // Pops run in WINDOW as well so a lone entry reaches the bank two cycles after its push.
  assign pop_c      = !VSync && !empty_c && !flush_c && (state_q != S_ACTIVE);
  assign last_pop_c = pop_c && (count_c == CNT_W'(1)) && !push_ok_c;

  vga_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET),
    .push      (push_c),
    .push_data (push_entry_c),
    .pop       (pop_c),
    .flush     (flush_c),
    .rd_data   (rd_entry_c),
    .count     (count_c),
    .full      (full_c),
    .empty     (empty_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACTIVE: if (vs_fall_c) state_d = S_WINDOW;
      S_WINDOW: if (!empty_c && !flush_c && !last_pop_c) state_d = S_DRAIN;
      S_DRAIN:  if (flush_c || empty_c || last_pop_c) state_d = S_WINDOW;
      default:  state_d = S_ACTIVE;
    endcase
    if (VSync) state_d = S_ACTIVE;
  end

  // A drop in the same cycle as a clear leaves overflow flagged.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf_c)             ovf_d = 1'b0;
    if (push_c && full_c)      ovf_d = 1'b1;
  end

  always_comb begin
    mem_write_d = pop_c;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    if (pop_c) begin
      mem_addr_d = rd_entry_c.addr;
      mem_data_d = rd_entry_c.data;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_ACTIVE;
      vs_q        <= 1'b1;
      ovf_q       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      vs_q        <= VSync;
      ovf_q       <= ovf_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

`ifdef VGA_SCHED_FRAMECNT_EN
  logic [3:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_q;
    if (vs_fall_c) frame_d = frame_q + 4'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) frame_q <= '0;
    else        frame_q <= frame_d;
  end

  assign frame_c = frame_q;
`else
  assign frame_c = 4'd0;
`endif

  always_comb begin
    status_c                          = '0;
    status_c[ST_VS]                   = ~VSync;
    status_c[ST_EMPTY]                = empty_c;
    status_c[ST_FULL]                 = full_c;
    status_c[ST_OVF]                  = ovf_q;
    status_c[ST_FRAME_HI:ST_FRAME_LO] = frame_c;
  end

  assign pb.OUT_DATA = status_c;
  assign MemWrite    = mem_write_q;
  assign MemAddr     = mem_addr_q;
  assign MemData     = mem_data_q;
  assign Full        = full_c;

endmodule
